// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor (master) and the PLL/system side (slave).
// The sw_pll_req request line exists only when PLL_SW_RESET_EN is defined.
interface pll_lock_supervisor_if;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       fault;
    logic [3:0] retry_count;
    logic [7:0] lost_lock_count;
    logic [2:0] state;
`ifdef PLL_SW_RESET_EN
    logic       sw_pll_req;

    modport master (
        input  pll_locked, sw_pll_req,
        output pll_rst, sys_reset_n, fault, retry_count, lost_lock_count, state
    );
    modport slave (
        output pll_locked, sw_pll_req,
        input  pll_rst, sys_reset_n, fault, retry_count, lost_lock_count, state
    );
`else
    modport master (
        input  pll_locked,
        output pll_rst, sys_reset_n, fault, retry_count, lost_lock_count, state
    );
    modport slave (
        output pll_locked,
        input  pll_rst, sys_reset_n, fault, retry_count, lost_lock_count, state
    );
`endif
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for lock with timeout and retries,
// then holds system reset until lock is stable. Macro PLL_SW_RESET_EN adds a software re-sequence request.
module pll_lock_supervisor #(
    parameter int unsigned RST_PULSE_CYC    = 64,
    parameter int unsigned LOCK_TIMEOUT_CYC = 742500,
    parameter int unsigned LOCK_STABLE_CYC  = 1024,
    parameter int unsigned RETRY_MAX        = 3
) (
    input  logic                         clk_74a,
    input  logic                         reset_n,
    pll_lock_supervisor_if.master        pll_if
);
    localparam int unsigned MAX_AB      = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
    localparam int unsigned CNT_MAX_VAL = (MAX_AB > LOCK_STABLE_CYC) ? MAX_AB : LOCK_STABLE_CYC;
    localparam int unsigned CNT_W       = $clog2(CNT_MAX_VAL + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [4:0]       RETRY_LIMIT  = 5'(RETRY_MAX);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sync_q;
    logic [3:0]       retry_q, retry_d;
    logic [7:0]       lost_q, lost_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_reset_n_q, sys_reset_n_d;
    logic             fault_q, fault_d;
    logic             locked_s;
    logic             sw_req;

    assign locked_s = sync_q[1];

`ifdef PLL_SW_RESET_EN
    assign sw_req = pll_if.sw_pll_req;
`else
    assign sw_req = 1'b0;
`endif

    // Two-flop synchronizer for the asynchronous PLL locked output.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
        end else begin
            // NOTE: non-blocking assignment keeps every flop sampling pre-edge values; blocking here would collapse the two stages into one.
            sync_q <= {sync_q[0], pll_if.pll_locked};
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
        state_d = state_q;
        retry_d = retry_q;
        lost_d  = lost_q;

        case (state_q)
            RESET_PLL: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // Lock seen on the timeout cycle takes priority over the timeout.
                if (locked_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
                    state_d = (({1'b0, retry_q} + 5'd1) < RETRY_LIMIT) ? RESET_PLL : FAULT;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    retry_d = 4'd0;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = RESET_PLL;
                    lost_d  = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = RESET_PLL;
            end
        endcase

        // Software request re-sequences without touching the health counters.
        if (sw_req && (state_q == WAIT_LOCK || state_q == STABLE || state_q == RUN)) begin
            state_d = RESET_PLL;
            retry_d = retry_q;
            lost_d  = lost_q;
        end
    end

    // Counter restarts on any state change and otherwise saturates.
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == '1) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_comb begin
        pll_rst_d     = (state_d == RESET_PLL) || (state_d == FAULT);
        sys_reset_n_d = (state_d == RUN);
        fault_d       = (state_d == FAULT);
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RESET_PLL;
            cnt_q         <= '0;
            retry_q       <= 4'd0;
            lost_q        <= 8'd0;
            pll_rst_q     <= 1'b1;
            sys_reset_n_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            lost_q        <= lost_d;
            pll_rst_q     <= pll_rst_d;
            sys_reset_n_q <= sys_reset_n_d;
            fault_q       <= fault_d;
        end
    end

    assign pll_if.pll_rst         = pll_rst_q;
    assign pll_if.sys_reset_n     = sys_reset_n_q;
    assign pll_if.fault           = fault_q;
    assign pll_if.retry_count     = retry_q;
    assign pll_if.lost_lock_count = lost_q;
    assign pll_if.state           = state_q;

endmodule
